// File: rtl/cp0_intc_pkg.sv
// cp0_intc_pkg: shared definitions for the CP0 interrupt controller slice.
//   - Register addresses inside the cp0_intc mfc0/mtc0 window.
//   - Field positions of the NEST register and the IE global-enable bit.
//   - Width of a source index (sources are numbered 0..30, NUM_IRQ <= 31).
package cp0_intc_pkg;

    localparam logic [2:0] INTC_IE    = 3'd0;
    localparam logic [2:0] INTC_IMODE = 3'd1;
    localparam logic [2:0] INTC_IP    = 3'd2;
    localparam logic [2:0] INTC_ISR   = 3'd3;
    localparam logic [2:0] INTC_NEST  = 3'd4;
    localparam logic [2:0] INTC_RAW   = 3'd5;

    localparam int NEST_DEPTH_LSB = 0;
    localparam int NEST_DEPTH_MSB = 3;
    localparam int NEST_OVF_BIT   = 31;
    localparam int IE_GIE_BIT     = 31;

    // A source index always fits in 5 bits; value NUM_IRQ doubles as "none".
    localparam int IDX_W = 5;

endpackage

// File: rtl/cp0_intc_prio.sv
// cp0_intc_prio: lowest-set-index finder.
//   vec   in  W      request vector, bit 0 is the highest priority
//   valid out 1      at least one bit of vec is set
//   idx   out IDX_W  index of the lowest set bit (0 when valid is low)
module cp0_intc_prio
    import cp0_intc_pkg::*;
#(
    parameter int W = 31
) (
    input  logic [W-1:0]     vec,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    // Scan from the top down so the last hit is the lowest index.
    always_comb begin
        idx = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (vec[i]) idx = IDX_W'(i);
        end
    end

    assign valid = |vec;

endmodule

// File: rtl/cp0_intc.sv
// cp0_intc: CP0 interrupt controller slice.
//   clk, rst_n          clock, synchronous active-low reset
//   reg_addr_i/_data_i  register select / write data for the cp0_intc window
//   reg_we_i            register write strobe
//   reg_data_o          read data, combinational from reg_addr_i
//   devices_interrupt   raw asynchronous device requests
//   exception, irq_ack  trap entry this cycle; irq_ack marks it as the
//                       presented hardware interrupt
//   eret                return from trap
//   hw_interrupt        request to the trap unit
//   hw_cause            index of the presented source, zero-extended
//
// Handshake: reg_we_i, exception, irq_ack and eret are single-cycle
// qualifiers sampled at posedge clk; there is no backpressure, each one
// asserted for a cycle is one event. hw_interrupt/hw_cause are level
// outputs valid every cycle; irq_ack only counts together with exception
// and while hw_interrupt is high.
module cp0_intc
    import cp0_intc_pkg::*;
#(
    parameter int NUM_IRQ     = 31,
    parameter int SYNC_STAGES = 2,
    parameter int NEST_DEPTH  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [2:0]         reg_addr_i,
    input  logic [31:0]        reg_data_i,
    input  logic               reg_we_i,
    output logic [31:0]        reg_data_o,
    input  logic [NUM_IRQ-1:0] devices_interrupt,
    input  logic               exception,
    input  logic               irq_ack,
    input  logic               eret,
    output logic               hw_interrupt,
    output logic [31:0]        hw_cause
);

    logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [NUM_IRQ-1:0] s, prev, rise;
    logic [NUM_IRQ-1:0] ie_en, imode, ip_edge, ip_edge_d, ip, elig;
    logic [NUM_IRQ-1:0] isr, isr_set;
    logic               gie, gie_top, ovf;
    logic [3:0]         depth;
    logic [NEST_DEPTH-1:0] stack;   // stack[0] is the oldest entry
    logic               best_vld, isr_vld, ack_take;
    logic [IDX_W-1:0]   best_idx, isr_idx, ceil_idx;
    logic               wr_ie, wr_imode, wr_ip, wr_nest;
    logic               unused_wdata;

    assign wr_ie    = reg_we_i && (reg_addr_i == INTC_IE);
    assign wr_imode = reg_we_i && (reg_addr_i == INTC_IMODE);
    assign wr_ip    = reg_we_i && (reg_addr_i == INTC_IP);
    assign wr_nest  = reg_we_i && (reg_addr_i == INTC_NEST);
    assign unused_wdata = ^reg_data_i;

    // Input synchronisers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= devices_interrupt;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~prev;
    // Level sources show the synchronised input directly; edge sources show
    // the latched bit. A latched bit survives a mode change.
    assign ip   = (imode & ip_edge) | (~imode & s);
    assign elig = ip & ie_en;

    cp0_intc_prio #(.W(NUM_IRQ)) u_best (.vec(elig), .valid(best_vld), .idx(best_idx));
    cp0_intc_prio #(.W(NUM_IRQ)) u_ceil (.vec(isr),  .valid(isr_vld),  .idx(isr_idx));

    assign ceil_idx     = isr_vld ? isr_idx : IDX_W'(NUM_IRQ);
    assign hw_interrupt = gie && best_vld && (best_idx < ceil_idx);
    assign hw_cause     = hw_interrupt ? 32'(best_idx) : 32'd0;
    assign ack_take     = exception && irq_ack && hw_interrupt;

    always_comb begin
        isr_set = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (best_idx == IDX_W'(i)) isr_set[i] = 1'b1;
        end
    end

    // Edge pending: clears first, then a new edge re-sets so it is not lost.
    always_comb begin
        ip_edge_d = ip_edge;
        if (wr_ip) ip_edge_d = ip_edge_d & ~(reg_data_i[NUM_IRQ-1:0] & imode);
        if (ack_take) ip_edge_d = ip_edge_d & ~(isr_set & imode);
        ip_edge_d = ip_edge_d | (rise & imode);
    end

    always_comb begin
        gie_top = 1'b0;
        for (int i = 0; i < NEST_DEPTH; i++) begin
            if (depth == 4'(i + 1)) gie_top = stack[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev    <= '0;
            ie_en   <= '0;
            imode   <= '0;
            ip_edge <= '0;
            isr     <= '0;
            gie     <= 1'b0;
            ovf     <= 1'b0;
            depth   <= '0;
            stack   <= '0;
        end else begin
            prev    <= s;
            ip_edge <= ip_edge_d;
            if (wr_ie)    ie_en <= reg_data_i[NUM_IRQ-1:0];
            if (wr_imode) imode <= reg_data_i[NUM_IRQ-1:0];
            // Clear first so an overflow in the same cycle still sticks.
            if (wr_nest && reg_data_i[NEST_OVF_BIT]) ovf <= 1'b0;

            if (ack_take) begin
                isr <= isr | isr_set;
            end else if (eret && !exception) begin
                isr <= isr & (isr - NUM_IRQ'(1));   // drop lowest set bit
            end

            // Trap entry beats return; both beat a software write of IE[31].
            if (exception) begin
                gie <= 1'b0;
                if (depth == 4'(NEST_DEPTH)) begin
                    for (int i = 0; i < NEST_DEPTH - 1; i++) stack[i] <= stack[i+1];
                    stack[NEST_DEPTH-1] <= gie;
                    ovf <= 1'b1;
                end else begin
                    for (int i = 0; i < NEST_DEPTH; i++) begin
                        if (depth == 4'(i)) stack[i] <= gie;
                    end
                    depth <= depth + 4'd1;
                end
            end else if (eret) begin
                if (depth != 4'd0) begin
                    gie   <= gie_top;
                    depth <= depth - 4'd1;
                end else begin
                    gie <= 1'b1;
                end
            end else if (wr_ie) begin
                gie <= reg_data_i[IE_GIE_BIT];
            end
        end
    end

    always_comb begin
        reg_data_o = '0;
        case (reg_addr_i)
            INTC_IE: begin
                reg_data_o[NUM_IRQ-1:0] = ie_en;
                reg_data_o[IE_GIE_BIT]  = gie;
            end
            INTC_IMODE: reg_data_o[NUM_IRQ-1:0] = imode;
            INTC_IP:    reg_data_o[NUM_IRQ-1:0] = ip;
            INTC_ISR:   reg_data_o[NUM_IRQ-1:0] = isr;
            INTC_NEST: begin
                reg_data_o[NEST_DEPTH_MSB:NEST_DEPTH_LSB] = depth;
                reg_data_o[NEST_OVF_BIT] = ovf;
            end
            INTC_RAW:   reg_data_o[NUM_IRQ-1:0] = s;
            default:    reg_data_o = '0;
        endcase
    end

endmodule
